// File: rtl/pdp_unit1d_pipe_arb.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : pdp_unit1d_pipe_arb
// Purpose  : Two-requester round-robin arbiter feeding a single registered
//            output stage (skid-free, 1-cycle latency, full throughput).
//            Per-requester saturating 16-bit accepted-beat counters.
// Config   : `define PDP_UNIT1D_ARB_BURST_EN to let a granted requester keep
//            priority for cfg_burst_len consecutive accepted beats.
//            Without it cfg_burst_len is ignored and grants alternate.
// Ports    : nvdla_core_clk / nvdla_core_rstn (async, active-low)
//            req0_*/req1_*  valid/ready/payload requesters
//            cfg_burst_len  beats per grant (0 behaves as 1)
//            cfg_cnt_clr    synchronous clear of beat counters
//            out_vld/out_pd/out_src/out_rdy  registered output stage
//            beat_cnt0/1    accepted beats per requester (saturating)
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module pdp_unit1d_pipe_arb #(
    parameter int PD_W = 185,
    parameter int BL_W = 4
) (
    input  logic            nvdla_core_clk,
    input  logic            nvdla_core_rstn,
    input  logic            req0_vld,
    input  logic [PD_W-1:0] req0_pd,
    output logic            req0_rdy,
    input  logic            req1_vld,
    input  logic [PD_W-1:0] req1_pd,
    output logic            req1_rdy,
    input  logic [BL_W-1:0] cfg_burst_len,
    input  logic            cfg_cnt_clr,
    output logic            out_vld,
    output logic [PD_W-1:0] out_pd,
    output logic            out_src,
    input  logic            out_rdy,
    output logic [15:0]     beat_cnt0,
    output logic [15:0]     beat_cnt1
);

    logic stage_rdy;
    logic sel0;
    logic sel1;
    logic gnt0;
    logic gnt1;
    logic any_gnt;
    logic last_gnt;

    // The stage can take a new beat when it is empty or being drained.
    assign stage_rdy = out_rdy | ~out_vld;

`ifdef PDP_UNIT1D_ARB_BURST_EN
    logic [BL_W-1:0] burst_cnt;     // beats still owed to burst_own
    logic            burst_own;
    logic            burst_held;
    logic            owner_vld;
    logic [BL_W-1:0] burst_len_m1;

    assign burst_held   = (burst_cnt != '0);
    assign owner_vld    = burst_own ? req1_vld : req0_vld;
    // Length is sampled only when a new burst starts, so a config change
    // lands at the next grant boundary.
    assign burst_len_m1 = (cfg_burst_len == '0) ? '0 : cfg_burst_len - 1'b1;

    always_comb begin
        sel0 = 1'b0;
        sel1 = 1'b0;
        if (burst_held && owner_vld) begin
            sel0 = ~burst_own;
            sel1 = burst_own;
        end else if (req0_vld && req1_vld) begin
            sel0 = last_gnt;
            sel1 = ~last_gnt;
        end else begin
            // Covers an owner that dropped vld: the other side wins at once.
            sel0 = req0_vld;
            sel1 = req1_vld;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            burst_cnt <= '0;
            burst_own <= 1'b0;
        end else if (any_gnt) begin
            if (burst_held && (gnt1 == burst_own)) begin
                burst_cnt <= burst_cnt - 1'b1;
            end else begin
                // New burst, or ownership taken over after the owner went idle.
                burst_cnt <= burst_len_m1;
                burst_own <= gnt1;
            end
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^cfg_burst_len;

    always_comb begin
        sel0 = 1'b0;
        sel1 = 1'b0;
        if (req0_vld && req1_vld) begin
            sel0 = last_gnt;
            sel1 = ~last_gnt;
        end else begin
            sel0 = req0_vld;
            sel1 = req1_vld;
        end
    end
`endif

    assign gnt0     = stage_rdy & sel0;
    assign gnt1     = stage_rdy & sel1;
    assign any_gnt  = gnt0 | gnt1;
    assign req0_rdy = gnt0;
    assign req1_rdy = gnt1;

    // Control state of the output stage and the arbiter.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            out_vld  <= 1'b0;
            out_src  <= 1'b0;
            last_gnt <= 1'b1;   // req0 wins the first tie
        end else begin
            if (stage_rdy) begin
                out_vld <= any_gnt;
            end
            if (any_gnt) begin
                out_src  <= gnt1;
                last_gnt <= gnt1;
            end
        end
    end

    // Payload is qualified by out_vld, so it needs no reset.
    always_ff @(posedge nvdla_core_clk) begin
        if (any_gnt) begin
            out_pd <= gnt1 ? req1_pd : req0_pd;
        end
    end

    // Saturating accepted-beat counters; clear has priority.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            beat_cnt0 <= '0;
            beat_cnt1 <= '0;
        end else if (cfg_cnt_clr) begin
            beat_cnt0 <= '0;
            beat_cnt1 <= '0;
        end else begin
            if (gnt0 && (beat_cnt0 != 16'hFFFF)) begin
                beat_cnt0 <= beat_cnt0 + 16'd1;
            end
            if (gnt1 && (beat_cnt1 != 16'hFFFF)) begin
                beat_cnt1 <= beat_cnt1 + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire
